smvm_stream_packer: RTL and testbench
=====================================

Name: smvm_stream_packer

Overview:
- Upstream feeder for the SMVM core. Accepts one sparse matrix-vector frame over a valid/ready beat stream: header, dense vector, then nonzeros as (value, column, row-end) tuples.
- Serialises the frame into the SMVM byte protocol: rows, cols, vector bytes, then alternating value/index cycles.
- Pads the nonzero list to a multiple of K and drives the terminating in_valid drop.
- Holds off the next frame until SMVM has finished its calculate and reset phases.

Parameters:
K, 4, nonzeros per ALU group; the nonzero count is padded to a multiple of K.
GAP_CYCLES, 6, minimum cycles m_valid stays low after the TERM cycle; must be >= SMVM ALU stall + 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream beat valid
s_ready  out  1  upstream beat accepted when s_valid & s_ready
s_val  in  8  header / vector / nonzero value
s_col  in  8  nonzero column index (nonzero beats only)
s_rowend  in  1  nonzero is the last of its row (becomes ipv)
s_eof  in  1  nonzero is the last of the frame
err_clr  in  1  clears sticky error flags
m_valid  out  1  to SMVM in_valid
m_val  out  8  to SMVM val_in
m_ipv  out  1  to SMVM ipv_in
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse in the TERM cycle
cfg_err  out  1  sticky: header with cols==0
proto_err  out  1  sticky: upstream bubble during the vector phase

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock clk. While reset is asserted:
  - state = IDLE;
  - m_valid, m_val, m_ipv, frame_done, cfg_err, proto_err, busy = 0;
  - all counters and latches = 0.
  - Reset mid-frame abandons the frame; no resume.
- s_ready is a combinational decode of state: 1 in IDLE, HDR, VEC, NZV, DROP; 0 elsewhere.
- m_* are registered: a beat accepted in cycle t drives m_* in cycle t+1.
- States:
  - IDLE: accept beat, rows_q <= s_val; go to HDR. m_valid = 0.
  - HDR: accept cols beat.
    - cols == 0: set cfg_err, go to DROP; nothing is emitted for this frame.
    - Otherwise: cols_q <= s_val; emit m_val = rows_q, m_valid = 1; go to EMITC.
  - EMITC: emit m_val = cols_q; vcnt <= 0; go to VEC.
  - VEC: each cycle emit m_valid = 1, m_val = s_val (or 0 on a bubble); vcnt++.
    - A bubble (no s_valid) still emits one element (m_val = 0) and sets proto_err, because SMVM cannot stall.
    - When vcnt reaches cols_q - 1, go to NZV.
  - NZV: emit m_valid = 1.
    - Beat accepted: m_val = s_val, m_ipv = s_rowend; latch s_col and s_eof.
    - Bubble: pad entry, m_val = 0, m_ipv = 0, latched col = 0, eof = 0. No error raised.
    - Go to NZI.
  - NZI: emit m_val = latched col, m_ipv = 0, m_valid = 1; gcnt = (gcnt + 1) mod K.
    - eof latched and new gcnt == 0: go to TERM.
    - eof latched and new gcnt != 0: go to PADV.
    - Otherwise: go to NZV.
  - PADV / PADI: emit value 0 / index 0, m_ipv = 0, m_valid = 1. PADI increments gcnt; gcnt == 0 goes to TERM, else back to PADV.
  - TERM: m_valid = 0, m_val = 0; frame_done = 1; gap counter <= GAP_CYCLES; gcnt <= 0; go to GAP.
  - GAP: m_valid = 0; count down; at 0 go to IDLE.
  - DROP: accept and discard beats until a beat with s_eof = 1; then go to IDLE. m_valid = 0 throughout.
- Each nonzero costs 2 output cycles; upstream sees s_ready low every other cycle in the nonzero phase.
- Header beats ignore s_col, s_rowend, s_eof. s_eof is honoured only in NZV and DROP.
- err_clr clears both sticky flags. An error set in the same cycle as err_clr wins.
- Padding entries never carry ipv = 1, so row results are unaffected.

Test Plan:
1. rows=2, cols=3, vec {1,2,3}, nz (5,c0,re0), (6,c2,re1), (7,c1,re1,eof) -> m_val sequence 2,3,1,2,3,5,0,6,2,7,1,0,0 with m_valid high; m_ipv high only on the 6 and 7 value cycles; then m_valid 0, frame_done pulse, s_ready low for GAP_CYCLES+1 cycles.
2. Exactly 4 nonzeros, eof on the 4th -> no pad cycles; TERM follows the 4th index cycle directly.
3. cols = 0 header followed by 3 nonzero beats with eof -> cfg_err = 1, m_valid never asserted, next frame emitted correctly; err_clr returns cfg_err to 0.
4. Bubble in NZV -> one (0,0) pair inserted with proto_err = 0; bubble in VEC -> m_val = 0 element emitted, proto_err = 1 until err_clr.
5. rst_n low mid-VEC -> m_valid / m_val drop to 0 immediately; after release s_ready = 1 and a new frame is processed correctly.
6. Back-to-back frames with SMVM attached -> second header is not accepted until GAP expires; both frames produce the correct SMVM data_out row results.

Source files
------------

// File: rtl/smvm_stream_packer.sv
// smvm_stream_packer: turns one sparse matrix-vector frame (header, dense vector, nonzero tuples)
// into the SMVM byte stream, pads nonzeros to a multiple of K and enforces an inter-frame gap.
module smvm_stream_packer #(
  parameter int K          = 4,
  parameter int GAP_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_val,
  input  logic [7:0] s_col,
  input  logic       s_rowend,
  input  logic       s_eof,
  input  logic       err_clr,
  output logic       m_valid,
  output logic [7:0] m_val,
  output logic       m_ipv,
  output logic       busy,
  output logic       frame_done,
  output logic       cfg_err,
  output logic       proto_err
);

  localparam int GW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_EMITC, S_VEC, S_NZV, S_NZI,
    S_PADV, S_PADI, S_TERM, S_GAP, S_DROP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      rows_q, rows_d;
  logic [7:0]      cols_q, cols_d;
  logic [7:0]      vcnt_q, vcnt_d;
  logic [7:0]      col_q, col_d;
  logic            eof_q, eof_d;
  logic [GW-1:0]   gcnt_q, gcnt_d, gcnt_inc;
  logic [CW-1:0]   gap_q, gap_d;
  logic            m_valid_d, m_ipv_d;
  logic [7:0]      m_val_d;
  logic            cfg_set, proto_set;

  assign gcnt_inc   = (gcnt_q == GW'(K - 1)) ? '0 : gcnt_q + 1'b1;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_TERM);

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      S_IDLE, S_HDR, S_VEC, S_NZV, S_DROP: s_ready = 1'b1;
      default:                             s_ready = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    vcnt_d    = vcnt_q;
    col_d     = col_q;
    eof_d     = eof_q;
    gcnt_d    = gcnt_q;
    gap_d     = gap_q;
    m_valid_d = 1'b0;
    m_val_d   = 8'd0;
    m_ipv_d   = 1'b0;
    cfg_set   = 1'b0;
    proto_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          rows_d  = s_val;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (s_valid) begin
          if (s_val == 8'd0) begin
            cfg_set = 1'b1;
            state_d = S_DROP;
          end else begin
            cols_d    = s_val;
            m_valid_d = 1'b1;
            m_val_d   = rows_q;
            state_d   = S_EMITC;
          end
        end
      end
      S_EMITC: begin
        m_valid_d = 1'b1;
        m_val_d   = cols_q;
        vcnt_d    = 8'd0;
        state_d   = S_VEC;
      end
      S_VEC: begin
        // SMVM cannot stall, so a bubble still consumes a vector slot as zero.
        m_valid_d = 1'b1;
        m_val_d   = s_valid ? s_val : 8'd0;
        proto_set = ~s_valid;
        vcnt_d    = vcnt_q + 8'd1;
        if (vcnt_q == cols_q - 8'd1) state_d = S_NZV;
      end
      S_NZV: begin
        m_valid_d = 1'b1;
        if (s_valid) begin
          m_val_d = s_val;
          m_ipv_d = s_rowend;
          col_d   = s_col;
          eof_d   = s_eof;
        end else begin
          col_d = 8'd0;
          eof_d = 1'b0;
        end
        state_d = S_NZI;
      end
      S_NZI: begin
        m_valid_d = 1'b1;
        m_val_d   = col_q;
        gcnt_d    = gcnt_inc;
        if (eof_q) state_d = (gcnt_inc == '0) ? S_TERM : S_PADV;
        else       state_d = S_NZV;
      end
      S_PADV: begin
        m_valid_d = 1'b1;
        state_d   = S_PADI;
      end
      S_PADI: begin
        m_valid_d = 1'b1;
        gcnt_d    = gcnt_inc;
        state_d   = (gcnt_inc == '0) ? S_TERM : S_PADV;
      end
      S_TERM: begin
        gap_d   = CW'(GAP_CYCLES);
        gcnt_d  = '0;
        eof_d   = 1'b0;
        state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= CW'(1)) state_d = S_IDLE;
      end
      S_DROP: begin
        if (s_valid && s_eof) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rows_q    <= 8'd0;
      cols_q    <= 8'd0;
      vcnt_q    <= 8'd0;
      col_q     <= 8'd0;
      eof_q     <= 1'b0;
      gcnt_q    <= '0;
      gap_q     <= '0;
      m_valid   <= 1'b0;
      m_val     <= 8'd0;
      m_ipv     <= 1'b0;
      cfg_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      vcnt_q    <= vcnt_d;
      col_q     <= col_d;
      eof_q     <= eof_d;
      gcnt_q    <= gcnt_d;
      gap_q     <= gap_d;
      m_valid   <= m_valid_d;
      m_val     <= m_val_d;
      m_ipv     <= m_ipv_d;
      // A new error in the same cycle as err_clr takes priority.
      cfg_err   <= cfg_set | (cfg_err & ~err_clr);
      proto_err <= proto_set | (proto_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_smvm_stream_packer.sv
// Randomised self-checking bench for smvm_stream_packer: frames are modelled as lists of
// values, the expected SMVM stream and row results are derived from them and compared.
module tb_smvm_stream_packer;

  localparam int K   = 4;
  localparam int GAP = 6;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       s_valid = 1'b0, s_rowend = 1'b0, s_eof = 1'b0, err_clr = 1'b0;
  logic [7:0] s_val = 8'd0, s_col = 8'd0;
  logic       s_ready, m_valid, m_ipv, busy, frame_done, cfg_err, proto_err;
  logic [7:0] m_val;

  smvm_stream_packer #(.K(K), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_val(s_val),
    .s_col(s_col), .s_rowend(s_rowend), .s_eof(s_eof), .err_clr(err_clr),
    .m_valid(m_valid), .m_val(m_val), .m_ipv(m_ipv), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  typedef struct {int val; int ipv; int cyc;} ent_t;
  typedef struct {int val; int ipv;} pair_t;
  typedef struct {int val; int col; bit re; bit eof; bit bub;} nz_t;

  int   cyc = 0;
  ent_t cap[$];
  int   fd_cnt = 0;
  int   fd_cyc = -1;
  bit   rdy_hist[int];
  bit   mv_hist[int];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    rdy_hist[cyc] = s_ready;
    mv_hist[cyc]  = m_valid;
    if (m_valid) cap.push_back('{val: int'(m_val), ipv: int'(m_ipv), cyc: cyc});
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- frame model ----------------
  int    f_rows, f_cols;
  int    f_vec[$];
  bit    f_vbub[$];
  nz_t   f_nz[$];
  pair_t exp_q[$];

  task automatic add_nz(input int val, input int col, input bit re, input bit eof, input bit bub);
    f_nz.push_back('{val: val, col: col, re: re, eof: eof, bub: bub});
  endtask

  task automatic gen_frame(input int cols, input int nnz, input bit vbub_en, input bit nzbub_en);
    f_cols = cols;
    f_rows = 0;
    f_vec.delete();
    f_vbub.delete();
    f_nz.delete();
    for (int i = 0; i < cols; i++) begin
      f_vec.push_back(int'($urandom_range(1, 255)));
      f_vbub.push_back(vbub_en && ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < nnz; i++) begin
      if (nzbub_en && $urandom_range(0, 3) == 0)
        add_nz(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), 1'b1, 1'b0, 1'b1);
      add_nz(int'($urandom_range(0, 255)), int'($urandom_range(0, cols - 1)),
             (i == nnz - 1) ? 1'b1 : 1'($urandom_range(0, 1)), i == nnz - 1, 1'b0);
    end
    foreach (f_nz[i]) if (!f_nz[i].bub && f_nz[i].re) f_rows++;
  endtask

  // Expected stream: header, vector (bubbles as 0), value/index pairs, zero pairs up to a multiple of K.
  task automatic build_expected();
    int n;
    exp_q.delete();
    if (f_cols == 0) return;
    exp_q.push_back('{f_rows, 0});
    exp_q.push_back('{f_cols, 0});
    foreach (f_vec[i]) exp_q.push_back('{f_vbub[i] ? 0 : f_vec[i], 0});
    n = 0;
    foreach (f_nz[i]) begin
      if (f_nz[i].bub) begin
        exp_q.push_back('{0, 0});
        exp_q.push_back('{0, 0});
      end else begin
        exp_q.push_back('{f_nz[i].val, int'(f_nz[i].re)});
        exp_q.push_back('{f_nz[i].col, 0});
      end
      n++;
    end
    while (n % K != 0) begin
      exp_q.push_back('{0, 0});
      exp_q.push_back('{0, 0});
      n++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input bit v, input int val, input int col, input bit re,
                           input bit eof, output int acc_cyc);
    bit ok, r;
    ok = 1'b0;
    acc_cyc = -1;
    s_valid  = v;
    s_val    = val[7:0];
    s_col    = col[7:0];
    s_rowend = re;
    s_eof    = eof;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      r = s_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      ok = r;
    end
    s_valid = 1'b0;
    check("handshake", ok, 1'b1);
  endtask

  task automatic run_frame(input string tag, output int hdr_cyc);
    int fd0, c, n, bad, idx, acc, p, dcols, xv;
    bit got_fd;
    int yexp[$];
    int ydec[$];
    build_expected();
    cap.delete();
    fd0 = fd_cnt;
    send_beat(1'b1, f_rows, 0, 1'b0, 1'b0, hdr_cyc);
    send_beat(1'b1, f_cols, 0, 1'b0, 1'b0, c);
    for (int i = 0; i < f_cols; i++) send_beat(!f_vbub[i], f_vec[i], 0, 1'b0, 1'b0, c);
    foreach (f_nz[i])
      send_beat(!f_nz[i].bub, f_nz[i].val, f_nz[i].col, f_nz[i].re, f_nz[i].eof, c);
    if (f_cols == 0) begin
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_drop_no_valid"}, cap.size(), 0);
      check({tag, "_drop_no_done"}, fd_cnt, fd0);
      return;
    end
    got_fd = 1'b0;
    for (int t = 0; t < 200 && !got_fd; t++) begin
      @(posedge clk);
      #1;
      got_fd = (fd_cnt != fd0);
    end
    check({tag, "_done"}, got_fd, 1'b1);
    check({tag, "_len"}, cap.size(), exp_q.size());
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    if (n > 0) begin
      bad = -1;
      for (int i = 0; i < n && bad < 0; i++)
        if (cap[i].val != exp_q[i].val || cap[i].ipv != exp_q[i].ipv || cap[i].cyc != cap[0].cyc + i)
          bad = i;
      idx = (bad < 0) ? 0 : bad;
      check({tag, "_val"}, cap[idx].val, exp_q[idx].val);
      check({tag, "_ipv"}, cap[idx].ipv, exp_q[idx].ipv);
      check({tag, "_contig"}, cap[idx].cyc, cap[0].cyc + idx);
      check({tag, "_term_after_last"}, fd_cyc, cap[n - 1].cyc);
    end
    // Row results straight from the matrix, and as SMVM would compute them from the stream.
    acc = 0;
    foreach (f_nz[i]) if (!f_nz[i].bub) begin
      acc += f_nz[i].val * (f_vbub[f_nz[i].col] ? 0 : f_vec[f_nz[i].col]);
      if (f_nz[i].re) begin
        yexp.push_back(acc);
        acc = 0;
      end
    end
    if (cap.size() == exp_q.size() && cap.size() >= 2) begin
      dcols = cap[1].val;
      acc = 0;
      for (p = 2 + dcols; p + 1 < cap.size(); p += 2) begin
        xv = (cap[p + 1].val < dcols) ? cap[2 + cap[p + 1].val].val : 0;
        acc += cap[p].val * xv;
        if (cap[p].ipv != 0) begin
          ydec.push_back(acc);
          acc = 0;
        end
      end
      check({tag, "_nrows"}, ydec.size(), yexp.size());
      for (int i = 0; i < ydec.size() && i < yexp.size(); i++)
        check({tag, "_row_result"}, ydec[i], yexp[i]);
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h, c, n, prev_fd, fd_before, ones;
    int lit[13];
    lit = '{2, 3, 1, 2, 3, 5, 0, 6, 2, 7, 1, 0, 0};

    #12;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_val", m_val, 8'd0);
    check("rst_m_ipv", m_ipv, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed reference frame.
    f_rows = 2;
    f_cols = 3;
    f_vec  = '{1, 2, 3};
    f_vbub = '{1'b0, 1'b0, 1'b0};
    f_nz.delete();
    add_nz(5, 0, 1'b0, 1'b0, 1'b0);
    add_nz(6, 2, 1'b1, 1'b0, 1'b0);
    add_nz(7, 1, 1'b1, 1'b1, 1'b0);
    fd_before = fd_cnt;
    run_frame("t1", h);
    check("t1_len_literal", cap.size(), 13);
    if (cap.size() == 13) begin
      for (int i = 0; i < 13; i++) check("t1_literal_val", cap[i].val, lit[i]);
      ones = 0;
      for (int i = 0; i < 13; i++) ones += cap[i].ipv;
      check("t1_ipv_count", ones, 2);
      check("t1_ipv_on_6", cap[7].ipv, 1);
      check("t1_ipv_on_7", cap[9].ipv, 1);
    end
    repeat (GAP + 4) @(posedge clk);
    #1;
    check("t1_fd_single_pulse", fd_cnt, fd_before + 1);
    n = 0;
    while (n < 40 && !rdy_hist[fd_cyc + n]) n++;
    check("t1_ready_low_run", n, GAP + 1);
    ones = 0;
    for (int i = 1; i <= GAP; i++) ones += int'(mv_hist[fd_cyc + i]);
    check("t1_valid_low_in_gap", ones, 0);

    // Exactly K nonzeros: no padding.
    gen_frame(int'($urandom_range(1, 5)), 4, 1'b0, 1'b0);
    run_frame("t2", h);
    check("t2_no_pad_len", cap.size(), 2 + f_cols + 8);

    // cols == 0 header: frame dropped, cfg_err sticky until err_clr.
    f_rows = 3;
    f_cols = 0;
    f_vec.delete();
    f_vbub.delete();
    f_nz.delete();
    add_nz(9, 1, 1'b0, 1'b0, 1'b0);
    add_nz(8, 2, 1'b1, 1'b0, 1'b0);
    add_nz(7, 0, 1'b1, 1'b1, 1'b0);
    run_frame("t3a", h);
    check("t3_cfg_err_set", cfg_err, 1'b1);
    gen_frame(3, 5, 1'b0, 1'b0);
    run_frame("t3b", h);
    check("t3_cfg_err_sticky", cfg_err, 1'b1);
    pulse_err_clr();
    check("t3_cfg_err_cleared", cfg_err, 1'b0);

    // NZV bubble: padded pair, no error.
    gen_frame(4, 6, 1'b0, 1'b0);
    f_nz.insert(1, '{val: 33, col: 3, re: 1'b1, eof: 1'b0, bub: 1'b1});
    run_frame("t4a", h);
    check("t4_nz_bubble_no_err", proto_err, 1'b0);
    // VEC bubble: zero element, proto_err sticky.
    gen_frame(5, 3, 1'b0, 1'b0);
    f_vbub[2] = 1'b1;
    run_frame("t4b", h);
    check("t4_vec_bubble_err", proto_err, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("t4_proto_err_sticky", proto_err, 1'b1);
    pulse_err_clr();
    check("t4_proto_err_cleared", proto_err, 1'b0);

    // Reset in the middle of the vector phase.
    gen_frame(4, 3, 1'b0, 1'b0);
    send_beat(1'b1, f_rows, 0, 1'b0, 1'b0, c);
    send_beat(1'b1, f_cols, 0, 1'b0, 1'b0, c);
    send_beat(1'b1, f_vec[0], 0, 1'b0, 1'b0, c);
    send_beat(1'b1, f_vec[1], 0, 1'b0, 1'b0, c);
    check("t5_valid_before_reset", m_valid, 1'b1);
    check("t5_val_before_reset", m_val, f_vec[1]);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid_in_reset", m_valid, 1'b0);
    check("t5_val_in_reset", m_val, 8'd0);
    check("t5_busy_in_reset", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_ready_after_reset", s_ready, 1'b1);
    @(posedge clk);
    #1;
    gen_frame(3, 4, 1'b0, 1'b0);
    run_frame("t5", h);

    // Randomised frames, with and without bubbles.
    for (int it = 0; it < 10; it++) begin
      gen_frame(int'($urandom_range(1, 8)), int'($urandom_range(1, 10)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_frame("rnd", h);
    end
    pulse_err_clr();

    // Back-to-back frames: second header waits for the gap.
    gen_frame(5, 7, 1'b0, 1'b0);
    run_frame("t6a", h);
    prev_fd = fd_cyc;
    gen_frame(6, 9, 1'b0, 1'b0);
    run_frame("t6b", h);
    check("t6_header_after_gap", h - prev_fd, GAP + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
